// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register.
// Priority per edge is redirect (flush to NOP) > stall (hold) > fetch.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
   localparam logic [31:0] PC_INIT   = RESET_PC & WORD_MASK;

   typedef enum logic [1:0] {
      OP_FETCH = 2'd0,
      OP_HOLD  = 2'd1,
      OP_FLUSH = 2'd2
   } op_t;

   op_t         op;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4;
   logic [31:0] instr_q;
   logic [31:0] instr_d;
   logic [31:0] id_pc_q;
   logic [31:0] id_pc_d;
   logic [31:0] id_pc4_q;
   logic [31:0] id_pc4_d;
   logic        valid_q;
   logic        valid_d;
   logic [31:0] count_q;
   logic [31:0] count_d;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      op = OP_FETCH;
      if (redirect) begin
         op = OP_FLUSH;
      end else if (stall) begin
         op = OP_HOLD;
      end
   end

   always_comb begin
      pc_d     = pc_q;
      instr_d  = instr_q;
      id_pc_d  = id_pc_q;
      id_pc4_d = id_pc4_q;
      valid_d  = valid_q;
      count_d  = count_q;
      case (op)
         OP_FETCH: begin
            pc_d     = pc_plus4;
            instr_d  = imem_instr;
            id_pc_d  = pc_q;
            id_pc4_d = pc_plus4;
            valid_d  = 1'b1;
            count_d  = count_q + 32'd1;
         end
         // squashed slot carries no PC so decode never sees a stale address
         OP_FLUSH: begin
            pc_d     = redirect_pc & WORD_MASK;
            instr_d  = NOP_WORD;
            id_pc_d  = 32'd0;
            id_pc4_d = 32'd0;
            valid_d  = 1'b0;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= PC_INIT;
         instr_q  <= NOP_WORD;
         id_pc_q  <= 32'd0;
         id_pc4_q <= 32'd0;
         valid_q  <= 1'b0;
         count_q  <= 32'd0;
      end else begin
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         id_pc_q  <= id_pc_d;
         id_pc4_q <= id_pc4_d;
         valid_q  <= valid_d;
         count_q  <= count_d;
      end
   end

   assign imem_pc        = pc_q;
   assign if_id_instr    = instr_q;
   assign if_id_pc       = id_pc_q;
   assign if_id_pc_plus4 = id_pc4_q;
   assign if_id_valid    = valid_q;
   assign fetch_count    = count_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS-style pipeline: owns the program counter and the IF/ID pipeline register.
- Drives `imem_pc` to the combinational instruction memory, which indexes by `pc[9:2]`, and captures the returned word into IF/ID for the decode stage.
- Handles hazard stalls from the hazard unit and branch redirects from the branch-resolve logic.
- Keeps a retired-fetch counter for bring-up debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush/reset (sll $0,$0,0).

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hazard unit: hold PC and IF/ID this cycle
- redirect  input  1  branch/jump resolved taken: load redirect_pc, squash fetched instruction
- redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0)
- imem_pc  output  32  current PC to instruction memory (= pc register)
- imem_instr  input  32  instruction word returned combinationally for imem_pc
- if_id_instr  output  32  registered instruction for decode
- if_id_pc  output  32  registered PC of if_id_instr
- if_id_pc_plus4  output  32  registered if_id_pc + 4
- if_id_valid  output  1  1 = if_id_instr is a real fetched instruction, 0 = bubble
- fetch_count  output  32  number of instructions accepted into IF/ID since reset

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-stall or mid-redirect):
  - pc = RESET_PC, if_id_instr = NOP_WORD, if_id_pc = 0, if_id_pc_plus4 = 0, if_id_valid = 0, fetch_count = 0.
  - Deassertion is sampled synchronously: the first update happens on the first rising edge with rst_n high.
- `imem_pc` is a direct register output, with no combinational path from any input.
- Per rising edge, priority is redirect > stall > normal.
  - Normal (redirect=0, stall=0):
    - pc <= pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
    - IF/ID <= {imem_instr, pc, pc+4}, if_id_valid <= 1, fetch_count <= fetch_count + 1.
  - Stall (redirect=0, stall=1): pc, IF/ID, if_id_valid and fetch_count all hold.
  - Redirect (redirect=1, stall ignored):
    - pc <= {redirect_pc[31:2], 2'b00}.
    - IF/ID <= NOP_WORD, if_id_pc <= 0, if_id_pc_plus4 <= 0, if_id_valid <= 0.
    - fetch_count holds.
- Latency:
  - Instruction at PC p appears on if_id_* one edge after imem_pc = p, absent stall/redirect.
  - After a redirect edge, the target instruction appears on IF/ID at the following edge (one bubble).
- fetch_count wraps 32'hFFFF_FFFF -> 0 silently.
- X on stall/redirect while rst_n=1 is illegal; the bench asserts on it.
- No combinational loop: redirect/stall affect only next-state logic.

Test Plan:
- Reset then 4 free-running edges, memory word[k] = 32'h1000_0000+k -> imem_pc 0,4,8,C,10; if_id_instr 1000_0000..1000_0003; if_id_pc 0..C; valid 1 from first edge; fetch_count 4.
- Stall held 2 cycles at pc=8 -> imem_pc stays 8, if_id_pc stays 4, fetch_count unchanged; on release the next edge gives if_id_pc=8, imem_pc=C.
- Redirect with redirect_pc=32'h0000_0027 at pc=10 -> next edge: imem_pc=24, if_id_valid=0, if_id_instr=0; following edge: if_id_pc=24, valid=1.
- Redirect and stall asserted together at pc=C, redirect_pc=40 -> redirect wins: imem_pc=40, IF/ID flushed, fetch_count holds.
- rst_n pulsed low mid-stall between clock edges -> outputs reset immediately (no clk edge), imem_pc=RESET_PC; with RESET_PC=32'h100, the first post-reset edge fetches 0x100.
- pc forced via redirect to 32'hFFFF_FFFC -> next normal edge: imem_pc=0, if_id_pc=FFFF_FFFC, if_id_pc_plus4=0.
